alu_result_bcd: RTL

Downstream consumer of the 8-bit add/subtract ALU in the calculator datapath. Captures one ALU result on a start strobe: Sum, carry-out C_8, the Add_Sub mode and the ALB compare flag. Converts it to sign plus BCD digits with an iterative shift-add-3 (double-dabble) engine, one iteration per clock. Feeds the seven-segment display driver through a busy/done handshake.

---
 rtl/alu_result_bcd.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/alu_result_bcd.sv
// rtl/alu_result_bcd.sv - ALU result capture and sign + BCD conversion (double dabble)
// Optional: BCD_BLANK_LEADING_ZERO_EN replaces leading zero digits with 4'hF at output latch.
module alu_result_bcd #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      sum,
  input  logic                  c_8,
  input  logic                  add_sub,
  input  logic                  alb,
  output logic                  busy,
  output logic                  done,
  output logic                  sign,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int MAG_W = WIDTH + 1;
  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + MAG_W;
  localparam int CNT_W = $clog2(MAG_W + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state, state_next;
  logic [SR_W-1:0]     sr, sr_next, sr_adj;
  logic [CNT_W-1:0]    cnt, cnt_next;
  logic                sign_cap, sign_cap_next;
  logic                busy_next, done_next, sign_next;
  logic [BCD_W-1:0]    bcd_next, out_digits;
  logic [WIDTH-1:0]    neg_sum;
  logic [MAG_W-1:0]    cap_mag;
  logic                cap_sign;
  logic [BCD_W-1:0]    acc;

  assign neg_sum = (~sum) + {{(WIDTH-1){1'b0}}, 1'b1};
  assign acc     = sr[SR_W-1 -: BCD_W];

  // Subtraction with A<B yields a two's-complement sum; carry is meaningless there.
  always_comb begin
    cap_mag  = {1'b0, sum};
    cap_sign = 1'b0;
    if (!add_sub) begin
      cap_mag = {c_8, sum};
    end else if (alb) begin
      cap_mag  = {1'b0, neg_sum};
      cap_sign = 1'b1;
    end
  end

  always_comb begin
    sr_adj = sr;
    for (int d = 0; d < DIGITS; d++) begin
      if (sr[MAG_W + 4*d +: 4] >= 4'd5) begin
        sr_adj[MAG_W + 4*d +: 4] = sr[MAG_W + 4*d +: 4] + 4'd3;
      end
    end
  end

`ifdef BCD_BLANK_LEADING_ZERO_EN
  logic blank_run;
  always_comb begin
    out_digits = acc;
    blank_run  = 1'b1;
    for (int d = DIGITS - 1; d >= 1; d--) begin
      if (blank_run && (acc[4*d +: 4] == 4'd0)) begin
        out_digits[4*d +: 4] = 4'hF;
      end else begin
        blank_run = 1'b0;
      end
    end
  end
`else
  assign out_digits = acc;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    sr_next       = sr;
    cnt_next      = cnt;
    sign_cap_next = sign_cap;
    busy_next     = busy;
    done_next     = 1'b0;
    bcd_next      = bcd;
    sign_next     = sign;
    case (state)
      S_IDLE: begin
        busy_next = 1'b0;
        if (start) begin
          sr_next       = {{BCD_W{1'b0}}, cap_mag};
          cnt_next      = '0;
          sign_cap_next = cap_sign;
          state_next    = S_CONV;
        end
      end
      S_CONV: begin
        busy_next = 1'b1;
        sr_next   = sr_adj << 1;
        cnt_next  = cnt + 1'b1;
        if (cnt == CNT_W'(MAG_W - 1)) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        busy_next  = 1'b0;
        done_next  = 1'b1;
        bcd_next   = out_digits;
        sign_next  = sign_cap;
        state_next = S_IDLE;
      end
      default: begin
        busy_next  = 1'b0;
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr       <= '0;
      cnt      <= '0;
      sign_cap <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd      <= '0;
      sign     <= 1'b0;
    end else begin
      sr       <= sr_next;
      cnt      <= cnt_next;
      sign_cap <= sign_cap_next;
      busy     <= busy_next;
      done     <= done_next;
      bcd      <= bcd_next;
      sign     <= sign_next;
    end
  end

endmodule
